// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch-side push and decode-side pop handshakes of the instruction buffer
// Ports (signals): opcode_vld/opcode0/opcode1 in, inst_buff_full back-pressure out,
//                  dec_vld/dec_opcode out, dec_ready in (directions as seen by the buffer)
interface inst_buffer_if;
  logic        opcode_vld;
  logic [31:0] opcode0;
  logic [31:0] opcode1;
  logic        inst_buff_full;
  logic        dec_vld;
  logic [31:0] dec_opcode;
  logic        dec_ready;
  modport master (
    output opcode_vld, opcode0, opcode1, dec_ready,
    input  inst_buff_full, dec_vld, dec_opcode
  );
  modport slave (
    input  opcode_vld, opcode0, opcode1, dec_ready,
    output inst_buff_full, dec_vld, dec_opcode
  );
endinterface

// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO of opcodes, two-wide push from fetch, one-wide FWFT pop to decode
// Ports: clk, reset (async, active-high), ib (slave: fetch push + decode pop handshakes),
//        flush (clears contents and halt latch), count (occupancy),
//        halt_latched (PIPE_HALT accepted), overflow_err (sticky dropped push)
module inst_buffer #(
  parameter int         DEPTH       = 16,
  parameter int         FULL_MARGIN = 6,
  parameter logic [7:0] PIPE_HALT   = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  inst_buffer_if.slave           ib,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halt_latched,
  output logic                   overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;
  logic [CW-1:0] n, space;
  logic          req, h0, h1, fits, push, pop;
  always_comb begin
    h0      = ib.opcode0[31:24] == PIPE_HALT;
    h1      = ib.opcode1[31:24] == PIPE_HALT;
    n       = h0 ? CW'(1) : CW'(2);
    space   = CW'(DEPTH) - count;
    req     = ib.opcode_vld && !flush && !halt_latched;
    fits    = space >= n;
    push    = req && fits;
    pop     = ib.dec_vld && ib.dec_ready && !flush;
    wr_ptr1 = wr_ptr + AW'(1);
  end
  assign ib.dec_vld        = count != '0;
  assign ib.dec_opcode     = ib.dec_vld ? mem[rd_ptr] : '0;
  assign ib.inst_buff_full = count > CW'(DEPTH - FULL_MARGIN);
  // Space is judged on the occupancy before this cycle's pop, so a pop never makes room for a same-cycle push.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt_latched <= 1'b0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt_latched <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(n);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (push ? n : '0) - CW'(pop);
      if (push && (h0 || h1)) halt_latched <= 1'b1;
      if (req && !fits) overflow_err <= 1'b1;
    end
  // A halt in opcode0 ends the stream, so the younger word is not stored.
  always_ff @(posedge clk)
    if (push) begin
      mem[wr_ptr] <= ib.opcode0;
      if (!h0) mem[wr_ptr1] <= ib.opcode1;
    end
endmodule
